// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register blocks: register address map,
// register file layout and a helper that builds the implemented-bit mask.
package gpio_pkg;

  localparam int REG_W = 32;

  typedef enum logic [1:0] {
    REG_RISE_EN = 2'd0,
    REG_FALL_EN = 2'd1,
    REG_PENDING = 2'd2,
    REG_MASK    = 2'd3
  } gpio_reg_e;

  typedef struct packed {
    logic [REG_W-1:0] rise_en;
    logic [REG_W-1:0] fall_en;
    logic [REG_W-1:0] pending;
    logic [REG_W-1:0] mask;
  } gpio_regs_t;

  // Ones in the low w bits; unimplemented register bits are ANDed with this.
  function automatic logic [REG_W-1:0] width_mask(input int w);
    logic [REG_W-1:0] m;
    m = '0;
    for (int i = 0; i < REG_W; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wishbone_p_if.sv
// Pipelined Wishbone bus bundle; dat_i/dat_o are named from the slave side.
interface wishbone_p_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        stall;

  modport slave (
    input  cyc, stb, we, adr, dat_i,
    output dat_o, ack, stall
  );

  modport master (
    output cyc, stb, we, adr, dat_i,
    input  dat_o, ack, stall
  );
endinterface

// File: rtl/gpio_edge_detect.sv
// Per-line rise/fall detector. The first cycle out of reset only captures the
// input so that lines already high at release do not look like edges.
module gpio_edge_detect #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gpio,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] prev_q;
  logic             primed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= gpio;
      primed_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_line
    assign rise[g] = primed_q &  gpio[g] & ~prev_q[g] & rise_en[g];
    assign fall[g] = primed_q & ~gpio[g] &  prev_q[g] & fall_en[g];
  end

endmodule

// File: rtl/wb_gpio_irq.sv
// GPIO edge-interrupt controller behind a pipelined Wishbone slave:
// per-line rise/fall enables, sticky W1C pending bits, mask and a level irq.
module wb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit IRQ_REG_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  wishbone_p_if.slave      wb,
  input  logic [WIDTH-1:0] gpio_sync_i,
  output logic             irq_o
);

  localparam logic [REG_W-1:0] WMASK = width_mask(WIDTH);

  gpio_regs_t       regs_q;
  logic             ack_q;
  logic [REG_W-1:0] rdata_q;
  logic [REG_W-1:0] rd_data;
  logic [REG_W-1:0] ev;
  logic [REG_W-1:0] w1c;
  logic [REG_W-1:0] pend_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             accept;
  logic             wr;
  logic             irq_c;
  gpio_reg_e        sel;
  logic             unused_adr;

  assign accept     = wb.cyc & wb.stb;
  assign wr         = accept & wb.we;
  assign sel        = gpio_reg_e'(wb.adr[3:2]);
  assign unused_adr = ^{wb.adr[31:4], wb.adr[1:0]};

  gpio_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .gpio    (gpio_sync_i),
    .rise_en (regs_q.rise_en[WIDTH-1:0]),
    .fall_en (regs_q.fall_en[WIDTH-1:0]),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    ev = '0;
    ev[WIDTH-1:0] = rise | fall;
  end

  // New edges are ORed in after the clear so a same-cycle event survives W1C.
  assign w1c       = (wr && sel == REG_PENDING) ? wb.dat_i : '0;
  assign pend_next = ((regs_q.pending & ~w1c) | ev) & WMASK;

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_RISE_EN: rd_data = regs_q.rise_en;
      REG_FALL_EN: rd_data = regs_q.fall_en;
      REG_PENDING: rd_data = regs_q.pending;
      REG_MASK:    rd_data = regs_q.mask;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (wr && sel == REG_RISE_EN) regs_q.rise_en <= wb.dat_i & WMASK;
      if (wr && sel == REG_FALL_EN) regs_q.fall_en <= wb.dat_i & WMASK;
      if (wr && sel == REG_MASK)    regs_q.mask    <= wb.dat_i & WMASK;
      regs_q.pending <= pend_next;
      ack_q          <= accept;
      rdata_q        <= (accept && !wb.we) ? rd_data : '0;
    end
  end

  assign irq_c = |(regs_q.pending & regs_q.mask);

  if (IRQ_REG_OUT) begin : g_irq_reg
    logic irq_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else         irq_q <= irq_c;
    end
    assign irq_o = irq_q;
  end else begin : g_irq_comb
    assign irq_o = irq_c;
  end

  // A master that drops cyc while an ack is due aborts it.
  assign wb.ack   = ack_q & wb.cyc;
  assign wb.dat_o = wb.ack ? rdata_q : '0;
  assign wb.stall = 1'b0;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomized + directed bench for wb_gpio_irq with a scoreboard and a
// register-level reference model.
module tb_wb_gpio_irq;

  localparam int WIDTH = 20;
  localparam logic [31:0] WM = (32'h1 << WIDTH) - 32'h1;

  typedef struct packed {
    logic [1:0]  adr;
    logic [31:0] dat;
  } exp_t;

  logic        clk_i;
  logic        rst_ni = 1'b1;
  logic [31:0] gpio_v = '0;
  logic        irq_o;

  wishbone_p_if wb_if();

  wb_gpio_irq #(.WIDTH(WIDTH), .IRQ_REG_OUT(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb          (wb_if),
    .gpio_sync_i (gpio_v[WIDTH-1:0]),
    .irq_o       (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // reference model state
  logic [31:0] m_rise, m_fall, m_pend, m_mask, m_prev;
  bit          m_primed;
  bit          irq_m;
  bit          have_pend;
  exp_t        pend_e;
  exp_t        q[$];

  int n_vec = 0;
  int n_bad = 0;
  bit done = 0;
  bit done_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_rise;
      2'd1:    return m_fall;
      2'd2:    return m_pend;
      default: return m_mask;
    endcase
  endfunction

  // One bus cycle. Called just after a rising edge; returns just after the next.
  task automatic cyc_t(input logic c, input logic s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [31:0] g,
                       input bit use_want, input logic [31:0] want);
    logic [31:0] gm, ev, n_rise, n_fall, n_pend, n_mask;
    bit acc, n_irq;
    wb_if.cyc   = c;
    wb_if.stb   = s;
    wb_if.we    = w;
    wb_if.adr   = {$urandom_range(0, 15), 12'h000, 2'b00, a, 2'b00} & 32'h0000_000C
                | ({$urandom} & 32'hFFFF_FFF3);
    wb_if.dat_i = d;
    gpio_v      = g;
    if (have_pend && c) q.push_back(pend_e);
    have_pend = 0;
    acc = c && s;
    if (acc) begin
      have_pend  = 1;
      pend_e.adr = a;
      pend_e.dat = w ? 32'h0 : (use_want ? want : m_read(a));
    end
    gm = g & WM;
    ev = m_primed ? (((gm & ~m_prev) & m_rise) | ((~gm & m_prev) & m_fall)) : 32'h0;
    n_rise = m_rise; n_fall = m_fall; n_mask = m_mask;
    n_pend = m_pend | ev;
    if (acc && w) begin
      case (a)
        2'd0: n_rise = d & WM;
        2'd1: n_fall = d & WM;
        2'd2: n_pend = (m_pend & ~d) | ev;
        default: n_mask = d & WM;
      endcase
    end
    n_irq = |(m_pend & m_mask);
    @(posedge clk_i);
    m_rise = n_rise; m_fall = n_fall; m_pend = n_pend; m_mask = n_mask;
    m_prev = gm; m_primed = 1; irq_m = n_irq;
    #1;
  endtask

  task automatic idle(input logic [31:0] g);
    cyc_t(0, 0, 0, 2'd0, 32'h0, g, 0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc_t(1, 1, 1, a, d, gpio_v, 0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, input bit use_want, input logic [31:0] want);
    cyc_t(1, 1, 0, a, $urandom, gpio_v, use_want, want);
  endtask

  task automatic do_reset(input logic [31:0] g);
    rst_ni = 1'b0;
    wb_if.cyc = 0; wb_if.stb = 0; wb_if.we = 0; wb_if.adr = '0; wb_if.dat_i = '0;
    gpio_v = g;
    m_rise = 0; m_fall = 0; m_pend = 0; m_mask = 0; m_prev = 0;
    m_primed = 0; irq_m = 0; have_pend = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // monitor: ack expected exactly when the scoreboard has an entry this cycle
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      chk("rst_ack", {31'h0, wb_if.ack}, 32'h0);
      chk("rst_dat_o", wb_if.dat_o, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
    end else begin
      chk("stall", {31'h0, wb_if.stall}, 32'h0);
      chk("irq", {31'h0, irq_o}, {31'h0, irq_m});
      chk("ack", {31'h0, wb_if.ack}, (q.size() > 0) ? 32'h1 : 32'h0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (wb_if.ack === 1'b1) chk($sformatf("dat_o_adr%0d", e.adr), wb_if.dat_o, e.dat);
      end else begin
        chk("idle_dat_o", wb_if.dat_o, 32'h0);
      end
    end
    if (done && !done_chk) begin
      done_chk = 1;
      chk("acks_outstanding", q.size(), 32'h0);
    end
  end

  initial begin
    #1;
    do_reset(32'h0);
    for (int a = 0; a < 4; a++) rd(2'(a), 1, 32'h0);

    // rising edge on bit0 sets PENDING, irq follows a cycle later
    idle(32'h0);
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h1);
    idle(32'h1);
    idle(32'h1);
    rd(2'd2, 1, 32'h1);

    // falling-only bit7 while bit0 toggles with rise disabled
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h80);
    idle(32'h81);
    idle(32'h01);
    idle(32'h00);
    idle(32'h01);
    rd(2'd2, 1, 32'h80);

    // W1C of one bit, then W1C racing a new edge on the same bit
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd0, 32'h3);
    idle(32'h0);
    idle(32'h3);
    rd(2'd2, 1, 32'h3);
    wr(2'd2, 32'h1);
    rd(2'd2, 1, 32'h2);
    idle(32'h1);
    cyc_t(1, 1, 1, 2'd2, 32'h2, 32'h3, 0, 32'h0);
    rd(2'd2, 1, 32'h2);

    // unmasking an already-pending bit raises irq; masking leaves PENDING
    wr(2'd3, 32'h0);
    idle(32'h3);
    wr(2'd3, 32'h2);
    idle(32'h3);
    rd(2'd2, 1, 32'h2);

    // bits above WIDTH read zero
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 1, WM);
    wr(2'd0, 32'h0);

    // four back-to-back reads
    wr(2'd1, 32'h0000_5A5A);
    for (int a = 0; a < 4; a++) rd(2'(a), 0, 32'h0);
    idle(gpio_v);

    // dropping cyc before the ack aborts it
    rd(2'd1, 0, 32'h0);
    idle(gpio_v);
    idle(gpio_v);

    // reset right after a write accept
    wr(2'd0, 32'h55);
    do_reset(gpio_v);
    for (int a = 0; a < 4; a++) rd(2'(a), 1, 32'h0);

    // release with all inputs high: no spurious pending
    do_reset(32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    idle(32'hFFFF_FFFF);
    idle(32'hFFFF_FFFF);
    rd(2'd2, 1, 32'h0);
    idle(gpio_v);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int k;
      logic [31:0] g;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      g = ($urandom_range(0, 2) == 0) ? (gpio_v ^ $urandom) : gpio_v;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 599) == 0) begin
        do_reset(g);
      end else if (k < 6) begin
        cyc_t(1, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d, g, 0, 32'h0);
      end else if (k == 6) begin
        cyc_t(1, 0, 0, 2'd0, d, g, 0, 32'h0);
      end else if (k == 7) begin
        cyc_t(0, 1, 1, 2'($urandom_range(0, 3)), d, g, 0, 32'h0);
      end else begin
        idle(g);
      end
    end
    idle(gpio_v);
    idle(gpio_v);

    done = 1;
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
